// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcodes, controller state encoding and the
// single-cycle ALU used by the controller.
package calc_pkg;

  localparam int RES_W     = 24;
  localparam int OPND_W    = 8;
  localparam int OPC_W     = 3;
  localparam int NUM_KEYS  = 3;
  localparam int MUL_STEPS = 8;

  localparam logic [OPC_W-1:0] OP_CLR  = 3'b000;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b010;
  localparam logic [OPC_W-1:0] OP_MUL  = 3'b011;
  localparam logic [OPC_W-1:0] OP_AND  = 3'b100;
  localparam logic [OPC_W-1:0] OP_OR   = 3'b101;
  localparam logic [OPC_W-1:0] OP_XOR  = 3'b110;
  localparam logic [OPC_W-1:0] OP_LOAD = 3'b111;

  // Button indices within KEY_n.
  localparam int KEY_LD_OPND = 0;
  localparam int KEY_LD_OPC  = 1;
  localparam int KEY_EXEC    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } calc_state_t;

  // Single-cycle opcodes; MUL is sequenced by the controller and leaves acc as is.
  function automatic logic [RES_W-1:0] alu_op(input logic [OPC_W-1:0]  opc,
                                               input logic [RES_W-1:0]  acc,
                                               input logic [OPND_W-1:0] opnd);
    logic [RES_W-1:0] ext;
    ext = {{(RES_W-OPND_W){1'b0}}, opnd};
    case (opc)
      OP_CLR:  alu_op = '0;
      OP_ADD:  alu_op = acc + ext;
      OP_SUB:  alu_op = acc - ext;
      OP_AND:  alu_op = acc & ext;
      OP_OR:   alu_op = acc | ext;
      OP_XOR:  alu_op = acc ^ ext;
      OP_LOAD: alu_op = ext;
      default: alu_op = acc;
    endcase
  endfunction

endpackage

// File: rtl/calc_control_if.sv
// Switch/button inputs and operand/opcode/result outputs of the calculator
// controller; the controller uses the slave view.
interface calc_control_if;
  import calc_pkg::*;

  logic [OPND_W-1:0]   SW;
  logic [NUM_KEYS-1:0] KEY_n;
  logic [OPND_W-1:0]   OpReg;
  logic                ShowOpReg;
  logic [OPC_W-1:0]    OpCode;
  logic                ShowOpCode;
  logic [RES_W-1:0]    OpResult;
  logic                busy;

  modport master (
    output SW, KEY_n,
    input  OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult, busy
  );

  modport slave (
    input  SW, KEY_n,
    output OpReg, ShowOpReg, OpCode, ShowOpCode, OpResult, busy
  );

endinterface

// File: rtl/button_debounce.sv
// One raw active-low button: 2-flop synchronizer, tick-counted debouncer and
// a one-cycle pulse on the released-to-pressed transition of the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic key_n,
  output logic press_evt
);

  localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;
  logic             raw_pressed;

  always_comb begin
    sync1_d     = key_n;
    sync2_d     = sync1_q;
    raw_pressed = ~sync2_q;
    lvl_d       = lvl_q;
    cnt_d       = cnt_q;
    // Any tick-free cycle holds the count; agreement with the level restarts it.
    if (raw_pressed == lvl_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = raw_pressed;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    evt_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign press_evt = evt_q;

endmodule

// File: rtl/calc_control.sv
// Calculator controller: debounced operand/opcode loads and an execute FSM
// with a single-cycle ALU path and an 8-cycle shift-add multiplier.
module calc_control
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           oneMsPulse,
  calc_control_if.slave  io
);

  logic [NUM_KEYS-1:0] press_evt;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    button_debounce #(
      .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .tick      (oneMsPulse),
      .key_n     (io.KEY_n[k]),
      .press_evt (press_evt[k])
    );
  end

  calc_state_t       state_q, state_d;
  logic [OPND_W-1:0] op_reg_q, op_reg_d;
  logic [OPC_W-1:0]  op_code_q, op_code_d;
  logic              show_op_reg_q, show_op_reg_d;
  logic              show_op_code_q, show_op_code_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [RES_W-1:0]  mcand_q, mcand_d;
  logic [OPND_W-1:0] mplier_q, mplier_d;
  logic [2:0]        step_q, step_d;
  logic [RES_W-1:0]  mul_sum;
  logic              busy;

  // The execute press cycle already counts as busy, so a load arriving with it is dropped.
  assign busy    = (state_q != ST_IDLE) || press_evt[KEY_EXEC];
  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d        = state_q;
    op_reg_d       = op_reg_q;
    op_code_d      = op_code_q;
    show_op_reg_d  = 1'b0;
    show_op_code_d = 1'b0;
    result_d       = result_q;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    step_d         = step_q;
    case (state_q)
      ST_IDLE: begin
        if (press_evt[KEY_EXEC]) begin
          if (op_code_q == OP_MUL) begin
            state_d  = ST_MUL;
            acc_d    = '0;
            mcand_d  = result_q;
            mplier_d = op_reg_q;
            step_d   = '0;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          if (press_evt[KEY_LD_OPND]) begin
            op_reg_d      = io.SW;
            show_op_reg_d = 1'b1;
          end
          if (press_evt[KEY_LD_OPC]) begin
            op_code_d      = io.SW[OPC_W-1:0];
            show_op_code_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        result_d = alu_op(op_code_q, result_q, op_reg_q);
        state_d  = ST_DONE;
      end
      ST_MUL: begin
        // Partial products stay in acc_q; OpResult only sees the final sum.
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + 3'd1;
        if (step_q == 3'(MUL_STEPS - 1)) begin
          result_d = mul_sum;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      op_reg_q       <= '0;
      op_code_q      <= '0;
      show_op_reg_q  <= 1'b0;
      show_op_code_q <= 1'b0;
      result_q       <= '0;
    end else begin
      state_q        <= state_d;
      op_reg_q       <= op_reg_d;
      op_code_q      <= op_code_d;
      show_op_reg_q  <= show_op_reg_d;
      show_op_code_q <= show_op_code_d;
      result_q       <= result_d;
    end
  end

  // Multiplier working registers are always loaded on MUL entry.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    step_q   <= step_d;
  end

  assign io.OpReg      = op_reg_q;
  assign io.ShowOpReg  = show_op_reg_q;
  assign io.OpCode     = op_code_q;
  assign io.ShowOpCode = show_op_code_q;
  assign io.OpResult   = result_q;
  assign io.busy       = busy;

endmodule

// File: tb/tb_calc_control.sv
// Randomized and directed bench for calc_control with a queue-based scoreboard
// and a behavioural calculator model.
module tb_calc_control;
  import calc_pkg::*;

  localparam int DEB  = 20;
  localparam int TICK = 4;
  localparam int HOLD = DEB + 5;

  typedef struct {
    logic [23:0] old_v;
    logic [23:0] new_v;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic oneMsPulse;

  calc_control_if io();

  calc_control #(.DEBOUNCE_MS(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .oneMsPulse (oneMsPulse),
    .io         (io.slave)
  );

  always #5 clk = ~clk;

  initial begin
    oneMsPulse = 1'b0;
    forever begin
      repeat (TICK - 1) @(negedge clk);
      oneMsPulse = 1'b1;
      @(negedge clk);
      oneMsPulse = 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  op_q[$];
  logic [2:0]  code_q[$];
  exp_t        res_q[$];

  logic [7:0]  m_opreg;
  logic [2:0]  m_opcode;
  logic [23:0] m_result;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model_exec();
    exp_t   e;
    longint r, o, v;
    r = longint'(m_result);
    o = longint'(m_opreg);
    case (m_opcode)
      3'd0:    v = 0;
      3'd1:    v = r + o;
      3'd2:    v = r - o;
      3'd3:    v = r * o;
      3'd4:    v = r & o;
      3'd5:    v = r | o;
      3'd6:    v = r ^ o;
      default: v = o;
    endcase
    e.old_v = m_result;
    e.new_v = v[23:0];
    e.len   = (m_opcode == 3'd3) ? 10 : 3;
    return e;
  endfunction

  task automatic model_press(input int k);
    exp_t e;
    if (k == 0) begin
      m_opreg = io.SW;
      op_q.push_back(io.SW);
    end else if (k == 1) begin
      m_opcode = io.SW[2:0];
      code_q.push_back(io.SW[2:0]);
    end else begin
      e = model_exec();
      res_q.push_back(e);
      m_result = e.new_v;
    end
  endtask

  task automatic press(input int mask, input bit bounce);
    for (int k = 0; k < 3; k++) if (mask[k]) model_press(k);
    if (bounce) begin
      repeat (10) begin
        for (int k = 0; k < 3; k++) if (mask[k]) io.KEY_n[k] = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clk);
      end
    end
    for (int k = 0; k < 3; k++) if (mask[k]) io.KEY_n[k] = 1'b0;
    repeat (HOLD * TICK) @(negedge clk);
    for (int k = 0; k < 3; k++) if (mask[k]) io.KEY_n[k] = 1'b1;
    repeat (HOLD * TICK) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_OpReg"},      32'(io.OpReg),      32'h0);
    chk({tag, "_OpCode"},     32'(io.OpCode),     32'h0);
    chk({tag, "_OpResult"},   32'(io.OpResult),   32'h0);
    chk({tag, "_ShowOpReg"},  32'(io.ShowOpReg),  32'h0);
    chk({tag, "_ShowOpCode"}, 32'(io.ShowOpCode), 32'h0);
    chk({tag, "_busy"},       32'(io.busy),       32'h0);
  endtask

  // Monitor: pops expectations whenever the DUT shows a load pulse or an execute run.
  initial begin
    exp_t       cur;
    int         bk;
    bit         have;
    logic [7:0] v8;
    logic [2:0] v3;
    bk   = 0;
    have = 1'b0;
    cur  = '{old_v: 24'h0, new_v: 24'h0, len: 0};
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bk   = 0;
        have = 1'b0;
      end else begin
        if (io.ShowOpReg) begin
          if (op_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ShowOpReg: pulse seen with OpReg=%0h, none expected", io.OpReg);
          end else begin
            v8 = op_q.pop_front();
            chk("OpReg_load", 32'(io.OpReg), 32'(v8));
          end
        end
        if (io.ShowOpCode) begin
          if (code_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ShowOpCode: pulse seen with OpCode=%0h, none expected", io.OpCode);
          end else begin
            v3 = code_q.pop_front();
            chk("OpCode_load", 32'(io.OpCode), 32'(v3));
          end
        end
        if (io.busy) begin
          bk++;
          if (bk == 1) begin
            if (res_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_busy: busy rose, no execute expected");
            end else begin
              cur  = res_q.pop_front();
              have = 1'b1;
            end
          end
          if (have && bk == cur.len - 1) chk("OpResult_before_update", 32'(io.OpResult), 32'(cur.old_v));
          if (have && bk == cur.len)     chk("OpResult_after_update",  32'(io.OpResult), 32'(cur.new_v));
        end else if (bk > 0) begin
          if (have) chk("busy_length", 32'(bk), 32'(cur.len));
          bk   = 0;
          have = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   sel;
    bit   b;
    reset    = 1'b1;
    io.SW    = 8'h00;
    io.KEY_n = 3'b111;
    m_opreg  = 8'h00;
    m_opcode = 3'h0;
    m_result = 24'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Bouncing operand press, then held: exactly one load
    io.SW = 8'h2A;
    press(1, 1'b1);
    chk("bounce_OpReg", 32'(io.OpReg), 32'h2A);

    // LOAD FF, ADD 01, SUB 01 twice
    io.SW = 8'h07; press(2, 1'b0);
    io.SW = 8'hFF; press(1, 1'b0);
    press(4, 1'b0);
    io.SW = 8'h01; press(3, 1'b0);
    press(4, 1'b0);
    chk("add_carry", 32'(io.OpResult), 32'h000100);
    io.SW = 8'h02; press(2, 1'b0);
    press(4, 1'b1);
    press(4, 1'b0);
    chk("sub_twice", 32'(io.OpResult), 32'h0000FE);

    // Wrap-around in both directions
    io.SW = 8'h07; press(2, 1'b0);
    io.SW = 8'h00; press(1, 1'b0);
    press(4, 1'b0);
    io.SW = 8'h02; press(2, 1'b0);
    io.SW = 8'h01; press(1, 1'b0);
    press(4, 1'b0);
    chk("sub_wrap", 32'(io.OpResult), 32'hFFFFFF);
    io.SW = 8'h01; press(2, 1'b0);
    press(4, 1'b0);
    chk("add_wrap", 32'(io.OpResult), 32'h000000);
    io.SW = 8'h02; press(2, 1'b0);
    press(4, 1'b0);
    chk("sub_wrap2", 32'(io.OpResult), 32'hFFFFFF);

    // 100 * 200
    io.SW = 8'h07; press(2, 1'b0);
    io.SW = 8'h64; press(1, 1'b0);
    press(4, 1'b0);
    io.SW = 8'hC8; press(1, 1'b0);
    io.SW = 8'h03; press(2, 1'b0);
    press(4, 1'b0);
    chk("mul_result", 32'(io.OpResult), 32'h004E20);

    // Operand press lands one tick after the execute press, inside MUL
    model_press(2);
    io.KEY_n[2] = 1'b0;
    repeat (TICK) @(negedge clk);
    io.SW = 8'h55;
    io.KEY_n[0] = 1'b0;
    repeat (HOLD * TICK) @(negedge clk);
    io.KEY_n = 3'b111;
    repeat (HOLD * TICK) @(negedge clk);
    chk("busy_discard_OpReg", 32'(io.OpReg), 32'hC8);
    chk("busy_discard_product", 32'(io.OpResult), 32'h3D0900);

    // Reset in MUL cycle 4 with execute still held
    res_q.push_back(model_exec());
    io.KEY_n[2] = 1'b0;
    for (int i = 0; i < 400 && !io.busy; i++) @(negedge clk);
    chk("mul_busy_rise", 32'(io.busy), 32'h1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_mul_reset");
    reset = 1'b0;
    res_q.delete();
    op_q.delete();
    code_q.delete();
    m_opreg  = 8'h00;
    m_opcode = 3'h0;
    m_result = 24'h0;
    repeat ((DEB - 2) * TICK) @(negedge clk);
    chk("held_key_no_early_press", 32'(io.busy), 32'h0);
    e = model_exec();
    res_q.push_back(e);
    m_result = e.new_v;
    repeat ((HOLD - DEB + 4) * TICK) @(negedge clk);
    io.KEY_n[2] = 1'b1;
    repeat (HOLD * TICK) @(negedge clk);

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      io.SW = 8'($urandom);
      sel   = int'($urandom_range(0, 5));
      b     = 1'($urandom_range(0, 1));
      case (sel)
        0:       press(1, b);
        1:       press(2, b);
        2:       press(3, b);
        default: press(4, b);
      endcase
    end

    repeat (50) @(negedge clk);
    chk("pending_opreg_events",  32'(op_q.size()),   32'h0);
    chk("pending_opcode_events", 32'(code_q.size()), 32'h0);
    chk("pending_exec_events",   32'(res_q.size()),  32'h0);
    chk("final_OpResult", 32'(io.OpResult), 32'(m_result));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_control.md
CALC_CONTROL -- requirements
Module: calc_control

Interface
REQ-001 DEBOUNCE_MS, default 20, number of consecutive stable oneMsPulse ticks required to accept a button level change.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 oneMsPulse  input  1  one-cycle tick every 1 ms from the shared timer.
REQ-005 SW  input  8  raw slide switches: operand value; SW[2:0] also supplies the opcode.
REQ-006 KEY_n  input  3  raw active-low buttons: [0] load operand, [1] load opcode, [2] execute.
REQ-007 OpReg  output  8  latched operand.
REQ-008 ShowOpReg  output  1  one-cycle pulse on each accepted operand load.
REQ-009 OpCode  output  3  latched opcode.
REQ-010 ShowOpCode  output  1  one-cycle pulse on each accepted opcode load.
REQ-011 OpResult  output  24  accumulator; display consumer reads it continuously.
REQ-012 busy  output  1  high while an execute operation is in progress.

Function
REQ-013 Each KEY_n bit SHALL pass through a 2-flop synchronizer and then a debouncer; a press event (one-cycle) SHALL occur when the debounced level goes from released to pressed.
REQ-014 The debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_MS consecutive oneMsPulse ticks; any bounce SHALL restart the count.
REQ-015 A KEY_n[0] press event in IDLE SHALL load OpReg<=SW and assert ShowOpReg on the next cycle.
REQ-016 A KEY_n[1] press event in IDLE SHALL load OpCode<=SW[2:0] and assert ShowOpCode on the next cycle.
REQ-017 If both events occur in the same cycle, both loads and both pulses SHALL occur.
REQ-018 FSM states: IDLE, EXEC, MUL, DONE.
REQ-019 IDLE: an execute press event SHALL go to MUL if OpCode==011, otherwise to EXEC.
REQ-020 EXEC (1 cycle): OpResult SHALL be updated per opcode, then the FSM SHALL go to DONE: 000 CLR ->0; 001 ADD ->OpResult+OpReg; 010 SUB ->OpResult-OpReg; 100 AND/101 OR/110 XOR with {16'b0,OpReg}; 111 LOAD ->{16'b0,OpReg}.
REQ-021 All arithmetic SHALL be modulo 2^24 (ADD wraps FFFFFF+01 ->000000; SUB wraps 000000-01 ->FFFFFF).
REQ-022 MUL SHALL be shift-add over exactly 8 cycles, one multiplier bit per cycle, LSB first, into a 24-bit product truncated to 24 bits; OpResult SHALL update once, on the last cycle, then the FSM SHALL go to DONE.
REQ-023 DONE (1 cycle): the FSM SHALL return to IDLE.
REQ-024 busy SHALL be high in EXEC, MUL and DONE; execute latency from press event to updated OpResult SHALL be 1 cycle (EXEC) or 8 cycles (MUL).
REQ-025 Press events on any button while busy SHALL be discarded, with no load and no pulse.
REQ-026 OpReg and OpCode SHALL NOT change while busy; MUL SHALL use snapshots taken at entry.

Reset
REQ-027 Reset SHALL set OpReg=0, OpCode=0, OpResult=0, ShowOpReg=0, ShowOpCode=0, busy=0, FSM=IDLE, all debounced levels=released, and all debounce counters=0.
REQ-028 Reset mid-MUL SHALL abort the operation with OpResult=0; no partial product SHALL appear on OpResult.
REQ-029 A button held through reset SHALL produce a press event only after DEBOUNCE_MS stable ticks following reset release.

Structure
REQ-030 Opcode localparams (CLR..LOAD) and FSM state encodings SHALL live in a shared package, calc_pkg, which the display side also imports.
REQ-031 Debounce logic SHALL be one sub-module, button_debounce (sync, counter, edge pulse), instantiated once per key.

Verification
REQ-032 KEY_n[0] bouncing 5 ms then held low 25 ms with SW=8'h2A -> exactly one ShowOpReg pulse, OpReg=8'h2A.
REQ-033 OpResult=0, LOAD 8'hFF, then ADD 8'h01 -> OpResult=24'h000100; then SUB 8'h01 twice -> 24'h0000FE.
REQ-034 OpResult=24'h000064, OpReg=8'hC8, MUL -> busy high for 10 cycles, OpResult=24'h004E20 exactly 8 cycles after the press event.
REQ-035 OpResult=24'hFFFFFF, ADD 8'h01 -> 24'h000000; then SUB 8'h01 -> 24'hFFFFFF.
REQ-036 Operand press during MUL with SW changed -> no ShowOpReg, OpReg unchanged, product uses the old OpReg.
REQ-037 Reset asserted at MUL cycle 4 -> all outputs at reset values next cycle, FSM=IDLE.
